// File: rtl/vec_seq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : vec_seq_pkg                                             |
// | Description : Shared types and constants for the vector lane          |
// |               sequencer: FSM state encoding, round-count helper and   |
// |               the 4-bit ALU control codes used by the physical ALUs.  |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
package vec_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // ALU control encoding shared with the scalar/vector ALUs
    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_NOR = 4'b1100;

    // Number of issue rounds needed to cover m lanes with 'lanes' ALUs
    function automatic int ROUNDS(input int m, input int lanes);
        return m / lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_lane_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : vec_lane_sequencer                                      |
// | Description : Time-shares LANES physical ALUs across an M-lane, N-bit |
// |               vector operation. Latches operands on start, issues one |
// |               LANES-wide slice per cycle, gathers the slice results   |
// |               and holds stall while the result is being built.        |
// | Options     : VSEQ_PERF_CNT_EN adds a saturating busy-cycle counter   |
// |               on output perfCycles.                                   |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module vec_lane_sequencer
    import vec_seq_pkg::*;
#(
    parameter int N     = 24,
    parameter int M     = 6,
    parameter int LANES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 flush,
    input  logic [M*N-1:0]       opA,
    input  logic [M*N-1:0]       opB,
    input  logic [3:0]           aluControl,
    output logic [LANES*N-1:0]   laneA,
    output logic [LANES*N-1:0]   laneB,
    output logic [3:0]           laneCtrl,
    output logic                 laneValid,
    input  logic [LANES*N-1:0]   laneResult,
    output logic [M*N-1:0]       result,
    output logic                 busy,
    output logic                 stall,
    output logic                 done
`ifdef VSEQ_PERF_CNT_EN
    ,
    output logic [31:0]          perfCycles
`endif
);

    localparam int c_ROUNDS = ROUNDS(M, LANES);
    localparam int c_RW     = (c_ROUNDS > 1) ? $clog2(c_ROUNDS) : 1;
    localparam int c_SLICE  = LANES * N;
    localparam logic [c_RW-1:0] c_LAST_ROUND = c_RW'(c_ROUNDS - 1);

    // Reject lane pools that do not evenly divide the vector
    if ((LANES < 1) || ((M % LANES) != 0)) begin : g_badLanes
        $error("vec_lane_sequencer: M (%0d) must be a multiple of LANES (%0d)", M, LANES);
    end

    seq_state_t         r_state;
    seq_state_t         w_nextState;
    logic [c_RW-1:0]    r_round;
    logic [M*N-1:0]     r_latchA;
    logic [M*N-1:0]     r_latchB;
    logic [3:0]         r_latchCtrl;
    logic [M*N-1:0]     r_result;
    logic               w_accept;
    logic               w_lastRound;
    int                 w_base;

    assign w_accept    = (r_state == IDLE) && start && !flush;
    assign w_lastRound = (r_round == c_LAST_ROUND);
    assign w_base      = int'(r_round) * c_SLICE;
    assign laneCtrl    = r_latchCtrl;
    assign result      = r_result;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and slice/handshake outputs; flush overrides every transition
    always_comb begin
        w_nextState = r_state;
        laneA       = '0;
        laneB       = '0;
        laneValid   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        stall       = 1'b0;
        case (r_state)
            IDLE: begin
                stall = start;
                if (start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                laneA     = r_latchA[w_base +: c_SLICE];
                laneB     = r_latchB[w_base +: c_SLICE];
                laneValid = 1'b1;
                busy      = 1'b1;
                stall     = 1'b1;
                if (w_lastRound) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (flush) begin
            w_nextState = IDLE;
        end
    end

    // Operand latches, round counter and result gather register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_round     <= '0;
            r_latchA    <= '0;
            r_latchB    <= '0;
            r_latchCtrl <= '0;
            r_result    <= '0;
        end else if (flush) begin
            r_round <= '0;
        end else if (w_accept) begin
            r_latchA    <= opA;
            r_latchB    <= opB;
            r_latchCtrl <= aluControl;
            r_round     <= '0;
        end else if (r_state == RUN) begin
            r_result[w_base +: c_SLICE] <= laneResult;
            if (w_lastRound) begin
                r_round <= '0;
            end else begin
                r_round <= r_round + c_RW'(1);
            end
        end
    end

`ifdef VSEQ_PERF_CNT_EN
    // Busy-cycle counter; saturates and survives flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfCycles <= '0;
        end else if (busy && (perfCycles != 32'hFFFF_FFFF)) begin
            perfCycles <= perfCycles + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vec_lane_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_vec_lane_sequencer                                   |
// | Description : Self-checking bench for vec_lane_sequencer. Runs a      |
// |               LANES=2 and a LANES=6 instance side by side with bench  |
// |               ALUs; honours VSEQ_PERF_CNT_EN when defined.            |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module tb_vec_lane_sequencer;
    import vec_seq_pkg::*;

    localparam int N  = 24;
    localparam int M  = 6;
    localparam int L  = 2;
    localparam int L6 = 6;
    localparam int W  = M * N;
    localparam int R  = M / L;

    logic            clk;
    logic            rst;
    logic            start;
    logic            flush;
    logic [W-1:0]    opA;
    logic [W-1:0]    opB;
    logic [3:0]      aluControl;

    logic [L*N-1:0]  laneA, laneB, laneResult;
    logic [3:0]      laneCtrl;
    logic            laneValid;
    logic [W-1:0]    result;
    logic            busy, stall, done;

    logic [W-1:0]    laneA6, laneB6, laneResult6;
    logic [3:0]      laneCtrl6;
    logic            laneValid6;
    logic [W-1:0]    result6;
    logic            busy6, stall6, done6;
`ifdef VSEQ_PERF_CNT_EN
    logic [31:0]     perfCycles, perfCycles6;
`endif

    int nChecks = 0;
    int nFails  = 0;

    vec_lane_sequencer #(.N(N), .M(M), .LANES(L)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .opA(opA), .opB(opB), .aluControl(aluControl),
        .laneA(laneA), .laneB(laneB), .laneCtrl(laneCtrl), .laneValid(laneValid),
        .laneResult(laneResult), .result(result),
        .busy(busy), .stall(stall), .done(done)
`ifdef VSEQ_PERF_CNT_EN
        , .perfCycles(perfCycles)
`endif
    );

    vec_lane_sequencer #(.N(N), .M(M), .LANES(L6)) dut6 (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .opA(opA), .opB(opB), .aluControl(aluControl),
        .laneA(laneA6), .laneB(laneB6), .laneCtrl(laneCtrl6), .laneValid(laneValid6),
        .laneResult(laneResult6), .result(result6),
        .busy(busy6), .stall(stall6), .done(done6)
`ifdef VSEQ_PERF_CNT_EN
        , .perfCycles(perfCycles6)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] aluRef(input logic [3:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
        case (c)
            c_ALU_AND: return a & b;
            c_ALU_OR:  return a | b;
            c_ALU_ADD: return a + b;
            c_ALU_SUB: return a - b;
            c_ALU_SLT: return ($signed(a) < $signed(b)) ? N'(1) : N'(0);
            c_ALU_NOR: return ~(a | b);
            default:   return a + b;
        endcase
    endfunction

    function automatic logic [W-1:0] pack6(input int v0, input int v1, input int v2,
                                           input int v3, input int v4, input int v5);
        logic [W-1:0] v;
        v = '0;
        v[0*N +: N] = N'(v0);
        v[1*N +: N] = N'(v1);
        v[2*N +: N] = N'(v2);
        v[3*N +: N] = N'(v3);
        v[4*N +: N] = N'(v4);
        v[5*N +: N] = N'(v5);
        return v;
    endfunction

    // Physical ALUs for both instances
    always_comb begin
        laneResult = '0;
        for (int l = 0; l < L; l++)
            laneResult[l*N +: N] = aluRef(laneCtrl, laneA[l*N +: N], laneB[l*N +: N]);
    end

    always_comb begin
        laneResult6 = '0;
        for (int l = 0; l < L6; l++)
            laneResult6[l*N +: N] = aluRef(laneCtrl6, laneA6[l*N +: N], laneB6[l*N +: N]);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model of the LANES=2 instance: phase -1 idle, 0..R-1 issuing, R finished
    int           mPhase;
    logic [W-1:0] mA, mB, mRes;
    logic [3:0]   mCtrl;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPhase <= -1;
            mA     <= '0;
            mB     <= '0;
            mCtrl  <= '0;
            mRes   <= '0;
        end else if (flush) begin
            mPhase <= -1;
        end else if (mPhase == -1) begin
            if (start) begin
                mA     <= opA;
                mB     <= opB;
                mCtrl  <= aluControl;
                mPhase <= 0;
            end
        end else if (mPhase < R) begin
            for (int k = mPhase * L; k < (mPhase + 1) * L; k++)
                mRes[k*N +: N] <= aluRef(mCtrl, mA[k*N +: N], mB[k*N +: N]);
            mPhase <= mPhase + 1;
        end else begin
            mPhase <= -1;
        end
    end

    // Every-cycle comparison of the LANES=2 instance against the model
    always @(negedge clk) begin : p_compare
        bit             run;
        logic [L*N-1:0] eA, eB;
        if (rst === 1'b0) begin
            run = (mPhase >= 0) && (mPhase < R);
            eA  = '0;
            eB  = '0;
            if (run) begin
                eA = mA[mPhase*L*N +: L*N];
                eB = mB[mPhase*L*N +: L*N];
            end
            check("cmp.laneValid", W'(laneValid), W'(run));
            check("cmp.laneA", W'(laneA), W'(eA));
            check("cmp.laneB", W'(laneB), W'(eB));
            check("cmp.laneCtrl", W'(laneCtrl), W'(mCtrl));
            check("cmp.busy", W'(busy), W'(mPhase >= 0));
            check("cmp.done", W'(done), W'(mPhase == R));
            check("cmp.stall", W'(stall), W'((start && mPhase == -1) || run));
            check("cmp.result", result, mRes);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                         input bit corrupt, output int doneAt, output int doneCnt,
                         output int validCnt, output int stallCnt,
                         output int done6At, output int stall6Cnt);
        doneAt = -1; doneCnt = 0; validCnt = 0; stallCnt = 0; done6At = -1; stall6Cnt = 0;
        opA = a; opB = b; aluControl = c; start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) begin doneAt = k; doneCnt++; end
            validCnt  += int'(laneValid);
            stallCnt  += int'(stall);
            if (done6) done6At = k;
            stall6Cnt += int'(stall6);
            tick();
            if (k == 0) begin
                start = 1'b0;
                if (corrupt) opA = '1;
            end
        end
    endtask

    logic [W-1:0] basicA, basicB, basicSum, prevA, prevB, prevRes;
    int doneAt, doneCnt, validCnt, stallCnt, done6At, stall6Cnt;
    int doneTimes[3];

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        opA = '0; opB = '0; aluControl = '0;
        basicA   = pack6(1, 2, 3, 4, 5, 6);
        basicB   = pack6(10, 20, 30, 40, 50, 60);
        basicSum = pack6(11, 22, 33, 44, 55, 66);
        prevA    = pack6(100, 200, 300, 400, 500, 600);
        prevB    = pack6(1, 2, 3, 4, 5, 6);
        prevRes  = pack6(99, 198, 297, 396, 495, 594);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.result", result, '0);
        check("reset.busy", W'(busy), '0);
        check("reset.done", W'(done), '0);
        check("reset.laneValid", W'(laneValid), '0);
        check("reset.laneCtrl", W'(laneCtrl), '0);
        check("reset.result6", result6, '0);
        tick();
        rst = 1'b0;
        tick();

        // Basic add
        runOp(basicA, basicB, c_ALU_ADD, 1'b0, doneAt, doneCnt, validCnt, stallCnt, done6At, stall6Cnt);
        check("basic.doneAt", W'(doneAt), W'(4));
        check("basic.doneCnt", W'(doneCnt), W'(1));
        check("basic.validCycles", W'(validCnt), W'(3));
        check("basic.stallCycles", W'(stallCnt), W'(4));
        check("basic.result", result, basicSum);
        check("basic.model", mRes, basicSum);
        check("lanes6.doneAt", W'(done6At), W'(2));
        check("lanes6.stallCycles", W'(stall6Cnt), W'(2));
        check("lanes6.result", result6, basicSum);
`ifdef VSEQ_PERF_CNT_EN
        check("perf.cycles", W'(perfCycles), W'(4));
        check("perf.cycles6", W'(perfCycles6), W'(2));
`endif

        // Operand change after start must not leak into the result
        runOp(basicA, basicB, c_ALU_ADD, 1'b1, doneAt, doneCnt, validCnt, stallCnt, done6At, stall6Cnt);
        check("isolate.doneAt", W'(doneAt), W'(4));
        check("isolate.result", result, basicSum);
        check("isolate.result6", result6, basicSum);

        // Subtract, leaving a known previous result for the flush case
        runOp(prevA, prevB, c_ALU_SUB, 1'b0, doneAt, doneCnt, validCnt, stallCnt, done6At, stall6Cnt);
        check("sub.doneAt", W'(doneAt), W'(4));
        check("sub.result", result, prevRes);

        // Flush in round 1
        opA = basicA; opB = basicB; aluControl = c_ALU_ADD; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("flush.busyBefore", W'(busy), W'(1));
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush.busyAfter", W'(busy), '0);
        check("flush.noDone", W'(done), '0);
        check("flush.result", result, pack6(11, 22, 297, 396, 495, 594));
        tick();
        runOp(basicA, basicB, c_ALU_ADD, 1'b0, doneAt, doneCnt, validCnt, stallCnt, done6At, stall6Cnt);
        check("afterFlush.doneAt", W'(doneAt), W'(4));
        check("afterFlush.result", result, basicSum);

        // Start held high: one op every five cycles
        doneCnt = 0;
        opA = prevA; opB = prevB; aluControl = c_ALU_OR; start = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) begin
                if (doneCnt < 3) doneTimes[doneCnt] = k;
                doneCnt++;
            end
            tick();
        end
        start = 1'b0;
        check("held.doneCnt", W'(doneCnt), W'(3));
        check("held.done0", W'(doneTimes[0]), W'(4));
        check("held.done1", W'(doneTimes[1]), W'(9));
        check("held.done2", W'(doneTimes[2]), W'(14));
        repeat (3) tick();

        // Asynchronous reset in round 1
        opA = basicA; opB = basicB; aluControl = c_ALU_ADD; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("midReset.busy", W'(busy), '0);
        check("midReset.done", W'(done), '0);
        check("midReset.laneValid", W'(laneValid), '0);
        check("midReset.laneA", W'(laneA), '0);
        check("midReset.result", result, '0);
        tick();
        tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vec_lane_sequencer.md
Name: vec_lane_sequencer

Overview:
Sequences one vector ALU operation (M lanes of N bits) over a smaller pool of LANES physical ALUs, so vector ALU area is time-shared across rounds. It sits in front of the EX stage vector ALU path. It latches both vector operands and the ALU control on start, issues one LANES-wide slice per cycle, and gathers the slice results into a full M*N result. It holds stall high while busy so the EX/MEM buffer enable can be gated until the result is complete.

Parameters:
N, 24, lane width in bits (matches scalar datapath width)
M, 6, number of vector lanes
LANES, 2, number of physical ALUs; M mod LANES must be 0 (elaboration error otherwise)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request to run one vector op; sampled only in IDLE
flush  in  1  synchronous abort; returns to IDLE without done
opA  in  M*N  vector operand A; lane i = bits [i*N +: N]
opB  in  M*N  vector operand B, same packing
aluControl  in  4  ALU operation code, latched on start
laneA  out  LANES*N  operand A slice driven to the physical ALUs
laneB  out  LANES*N  operand B slice driven to the physical ALUs
laneCtrl  out  4  latched aluControl driven to the physical ALUs
laneValid  out  1  high while a slice is being issued (RUN)
laneResult  in  LANES*N  combinational results from the physical ALUs
result  out  M*N  gathered vector result; held until the next accepted start
busy  out  1  high in RUN and DONE
stall  out  1  combinational: (start & IDLE) | RUN
done  out  1  one-cycle pulse, high in DONE

Behaviour:
- ROUNDS = M/LANES. The round counter is clog2(ROUNDS) bits wide, minimum 1.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start. On that edge, latch opA, opB and aluControl, and set round = 0.
- RUN:
  - laneA = latchedA[round*LANES*N +: LANES*N]; laneB likewise; laneValid = 1.
  - On each edge, result[round*LANES*N +: LANES*N] <= laneResult.
  - If round == ROUNDS-1 -> DONE; otherwise round++.
- DONE -> IDLE unconditionally after one cycle. A start seen in DONE is ignored (not queued).
- Latency: start accepted at edge 0. done is high during cycle ROUNDS+1. stall is high for exactly ROUNDS+1 cycles, counting the start cycle.
- Result slices that have not yet been written in an operation keep their previous values. result is only valid while done is high or after it.
- flush takes priority over every transition: next state IDLE, round = 0, result unchanged, done not pulsed. flush together with start in IDLE means the start is dropped.
- Outside RUN, laneA, laneB and laneValid are 0. laneCtrl always shows the latched value.
- Reset (asynchronous, mid-operation included) clears: state IDLE, round 0, all latches 0, result 0, laneCtrl 0, done 0, busy 0. stall follows its combinational equation.
- ROUNDS == 1 (LANES == M): RUN lasts one cycle, then DONE.
- Operands are not re-sampled during RUN; changes on opA/opB after start have no effect.

Optional Feature:
VSEQ_PERF_CNT_EN
- Defined: adds output perfCycles [31:0]. It increments on every clock edge where busy is high, saturates at 0xFFFFFFFF, and is cleared by rst only (not by flush).
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package vec_seq_pkg holds:
  - enum seq_state_t {IDLE, RUN, DONE}
  - localparam helper ROUNDS(M, LANES)
  - the 4-bit aluControl encoding constants already used by the ALUs
- No sub-module is required. The slice mux and the gather register stay in this module.
- The physical ALUs are instantiated by the parent and connected through the lane* ports.

Test Plan:
- Reset values: assert rst mid-RUN at round 1 -> state IDLE immediately; result = 0, done = 0, busy = 0, laneValid = 0.
- Basic op: N=24, M=6, LANES=2, bench ALU performs add; opA lanes = {1,2,3,4,5,6}, opB lanes = {10,20,30,40,50,60}; start for 1 cycle.
  - laneValid is high for 3 cycles.
  - done pulses in cycle 4; result lanes = {11,22,33,44,55,66}; stall is high for 4 cycles.
- Operand isolation: change opA to all 0xFFFFFF one cycle after start -> result identical to the basic op.
- Flush: flush in round 1 -> returns to IDLE, no done. result keeps lanes 0-1 from this op and lanes 2-5 from the previous op. A new start 1 cycle later completes normally.
- Start ignored: hold start high continuously.
  - Starts are accepted only in IDLE: one op every 5 cycles (3 RUN, 1 DONE, 1 IDLE).
  - done pulses at cycles 4, 9, 14.
- LANES=6 build: a single RUN cycle, done in cycle 2, stall high for 2 cycles. With VSEQ_PERF_CNT_EN, perfCycles = 2 after one op.
